load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 24 ++
 rtl/load_store_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// RAM-side bus of the load/store unit: one request/ack transaction per access.
// The master modport is the unit; the slave modport is the memory or a bench model.
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              oRAM_CE;
    logic              oRAM_RD;
    logic              oRAM_WR;
    logic [ADDR_W-1:0] oRAM_ADDR;
    logic [31:0]       oRAM_WDATA;
    logic [3:0]        oRAM_BE;
    logic [31:0]       iRAM_DATA;
    logic              iRAM_DONE;

    modport master (
        output oRAM_CE, oRAM_RD, oRAM_WR, oRAM_ADDR, oRAM_WDATA, oRAM_BE,
        input  iRAM_DATA, iRAM_DONE
    );

    modport slave (
        input  oRAM_CE, oRAM_RD, oRAM_WR, oRAM_ADDR, oRAM_WDATA, oRAM_BE,
        output iRAM_DATA, iRAM_DONE
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32 load/store unit: IDLE -> REQ -> RESP, with byte lanes, sign handling and a RAM timeout.
// Optional macro LSU_MISALIGN_TRAP_EN makes misaligned half/word accesses fail instead of being aligned down.
module load_store_unit #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSTART,
    input  logic [31:0] iIR,
    input  logic [31:0] iREG_OUT1,
    input  logic [31:0] iREG_OUT2,
    output logic        oBUSY,
    output logic        oDONE,
    output logic        oERR,
    output logic        oREG_WE,
    output logic [4:0]  oRD,
    output logic [31:0] oREG_IN,
    load_store_unit_if.master ram
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [4:0]        rd_q, rd_d;
    logic [2:0]        f3_q, f3_d;
    logic              store_q, store_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        off_q, off_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;

    logic        is_ld, is_st, f3_ok, misaligned, trap;
    logic [2:0]  f3;
    logic [1:0]  size, a_lo, off;
    logic [31:0] imm, ea, lane;
    logic        unused_bits;

    assign is_ld = (iIR[6:0] == 7'b0000011);
    assign is_st = (iIR[6:0] == 7'b0100011);
    assign f3    = iIR[14:12];
    assign size  = f3[1:0];
    assign imm   = is_st ? {{20{iIR[31]}}, iIR[31:25], iIR[11:7]}
                         : {{20{iIR[31]}}, iIR[31:20]};
    assign ea    = iREG_OUT1 + imm;
    assign a_lo  = ea[1:0];
    assign f3_ok = is_ld ? (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7) : (f3 < 3'd3);
    assign misaligned = (size == 2'd1 && a_lo[0]) || (size == 2'd2 && a_lo != 2'd0);
    assign unused_bits = ^{iIR[19:15], ea};

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = misaligned;
    assign off  = a_lo;
`else
    assign trap = 1'b0;
    // Misaligned accesses silently drop the offending low address bits.
    assign off  = (size == 2'd2) ? 2'd0 : (size == 2'd1) ? {a_lo[1], 1'b0} : a_lo;
`endif

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
            f3_q    <= '0;
            store_q <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            off_q   <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            f3_q    <= f3_d;
            store_q <= store_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            off_q   <= off_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        f3_d    = f3_q;
        store_d = store_q;
        err_d   = err_q;
        addr_d  = addr_q;
        off_d   = off_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (iSTART && (is_ld || is_st)) begin
                    rd_d    = iIR[11:7];
                    f3_d    = f3;
                    store_d = is_st;
                    addr_d  = {ea[ADDR_W-1:2], 2'b00};
                    off_d   = off;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    case (size)
                        2'd0:    begin be_d = 4'b0001 << off; wdata_d = {4{iREG_OUT2[7:0]}};  end
                        2'd1:    begin be_d = 4'b0011 << off; wdata_d = {2{iREG_OUT2[15:0]}}; end
                        default: begin be_d = 4'b1111;        wdata_d = iREG_OUT2;            end
                    endcase
                    if (!f3_ok || trap) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (ram.iRAM_DONE) begin
                    rdata_d = ram.iRAM_DATA;
                    state_d = RESP;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign lane = rdata_q >> {off_q, 3'b000};

    always_comb begin
        case (f3_q)
            3'd0:    oREG_IN = {{24{lane[7]}}, lane[7:0]};
            3'd1:    oREG_IN = {{16{lane[15]}}, lane[15:0]};
            3'd2:    oREG_IN = rdata_q;
            3'd4:    oREG_IN = {24'd0, lane[7:0]};
            3'd5:    oREG_IN = {16'd0, lane[15:0]};
            default: oREG_IN = '0;
        endcase
    end

    assign oBUSY   = (state_q != IDLE);
    assign oDONE   = (state_q == RESP);
    assign oERR    = oDONE && err_q;
    assign oREG_WE = oDONE && !err_q && !store_q && (rd_q != 5'd0);
    assign oRD     = rd_q;

    assign ram.oRAM_CE    = (state_q == REQ);
    assign ram.oRAM_RD    = ram.oRAM_CE && !store_q;
    assign ram.oRAM_WR    = ram.oRAM_CE && store_q;
    assign ram.oRAM_ADDR  = ram.oRAM_CE ? addr_q : '0;
    assign ram.oRAM_BE    = ram.oRAM_CE ? be_q : '0;
    assign ram.oRAM_WDATA = ram.oRAM_CE ? wdata_q : '0;
endmodule
